// File: rtl/mac_package.sv
// Shared types and helpers for the MAC output packer: control/flag bundles, pack modes, FSM states.
package mac_package;

  localparam int unsigned MAC_CNT_LEN  = 1024;
  localparam int unsigned PACKER_CNT_W = $clog2(MAC_CNT_LEN) + 1;

  typedef enum logic [1:0] {
    PACK_32 = 2'd0,
    PACK_16 = 2'd1,
    PACK_8  = 2'd2
  } pack_mode_t;

  typedef enum logic [1:0] {
    PackIdle,
    PackRun,
    PackDrain,
    PackDone
  } PACK_STATE;

  typedef struct packed {
    logic                    clear;
    logic                    enable;
    logic                    start;
    pack_mode_t              mode;
    logic                    sat_en;
    logic [PACKER_CNT_W-1:0] len;
  } ctrl_packer_t;

  typedef struct packed {
    logic                    busy;
    logic                    done;
    logic [PACKER_CNT_W-1:0] cnt;
    logic                    sat;
  } flags_packer_t;

  // Index of the last lane in a word for the given element width.
  function automatic logic [1:0] lanes_m1(input pack_mode_t mode);
    logic [1:0] n;
    case (mode)
      PACK_8:  n = 2'd3;
      PACK_16: n = 2'd1;
      default: n = 2'd0;
    endcase
    return n;
  endfunction

  // Byte strobe covering lanes 0..last_lane.
  function automatic logic [3:0] lane_strb(input pack_mode_t mode, input logic [1:0] last_lane);
    logic [3:0] s;
    case (mode)
      PACK_8: begin
        case (last_lane)
          2'd0:    s = 4'b0001;
          2'd1:    s = 4'b0011;
          2'd2:    s = 4'b0111;
          default: s = 4'b1111;
        endcase
      end
      PACK_16: s = last_lane[0] ? 4'b1111 : 4'b0011;
      default: s = 4'b1111;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/hwpe_stream_intf_stream.sv
// Minimal valid/ready stream interface with byte strobe.
interface hwpe_stream_intf_stream #(
  parameter int unsigned DATA_WIDTH = 32
);
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  logic                  valid;
  logic                  ready;
  logic [DATA_WIDTH-1:0] data;
  logic [STRB_WIDTH-1:0] strb;

  modport source (output valid, output data, output strb, input ready);
  modport sink   (input valid, input data, input strb, output ready);
endinterface

// File: rtl/mac_out_packer_sat.sv
// Per-element requantizer: clip or truncate a 32-bit signed result to 32/16/8 bits.
module mac_packer_sat
  import mac_package::*;
(
  input  logic [31:0] x,
  input  pack_mode_t  mode,
  input  logic        sat_en,
  output logic [31:0] y,
  output logic        clip
);

  logic fit16;
  logic fit8;

  // A value fits in W signed bits when bits [31:W-1] are all copies of the sign.
  assign fit16 = (&x[31:15]) | ~(|x[31:15]);
  assign fit8  = (&x[31:7])  | ~(|x[31:7]);

  always_comb begin
    y    = x;
    clip = 1'b0;
    case (mode)
      PACK_16: begin
        if (sat_en && !fit16) begin
          y    = x[31] ? 32'h0000_8000 : 32'h0000_7FFF;
          clip = 1'b1;
        end else begin
          y = {16'h0000, x[15:0]};
        end
      end
      PACK_8: begin
        if (sat_en && !fit8) begin
          y    = x[31] ? 32'h0000_0080 : 32'h0000_007F;
          clip = 1'b1;
        end else begin
          y = {24'h00_0000, x[7:0]};
        end
      end
      default: begin
        y    = x;
        clip = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/mac_out_packer.sv
// Requantizes MAC results and packs 1/2/4 elements per 32-bit word with byte strobe.
module mac_out_packer
  import mac_package::*;
#(
  parameter int unsigned CNT_W = PACKER_CNT_W
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         test_mode_i,
  hwpe_stream_intf_stream.sink         d_i,
  hwpe_stream_intf_stream.source       q_o,
  input  ctrl_packer_t                 ctrl_i,
  output flags_packer_t                flags_o
);

  PACK_STATE state_q, state_d;

  pack_mode_t       mode_q, mode_d;
  logic             sat_en_q, sat_en_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       lane_q, lane_d;
  logic [31:0]      pack_q, pack_d;
  logic [31:0]      out_data_q, out_data_d;
  logic [3:0]       out_strb_q, out_strb_d;
  logic             out_valid_q, out_valid_d;
  logic             sat_q, sat_d;

  logic        d_ready;
  logic        d_hs;
  logic        q_hs;
  logic        job_start;
  logic        is_last;
  logic        lane_full;
  logic        emit;
  logic [31:0] elem;
  logic        clip;
  logic [4:0]  shamt;
  logic [31:0] merged;
  logic        unused;

  assign unused = ^{test_mode_i, d_i.strb};

  mac_packer_sat u_sat (
    .x      (d_i.data),
    .mode   (mode_q),
    .sat_en (sat_en_q),
    .y      (elem),
    .clip   (clip)
  );

  assign job_start = ctrl_i.enable & ctrl_i.start & (state_q == PackIdle);
  assign d_hs      = d_i.valid & d_ready;
  assign q_hs      = ctrl_i.enable & out_valid_q & q_o.ready;
  assign is_last   = (cnt_q == (len_q - CNT_W'(1)));
  assign lane_full = (lane_q == lanes_m1(mode_q));
  assign emit      = d_hs & (lane_full | is_last);

  always_comb begin
    shamt = 5'd0;
    case (mode_q)
      PACK_16: shamt = {lane_q[0], 4'b0000};
      PACK_8:  shamt = {lane_q, 3'b000};
      default: shamt = 5'd0;
    endcase
  end

  // Unfilled lanes stay zero because pack_q is cleared after every emitted word.
  assign merged = pack_q | (elem << shamt);

  // FSM: state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= PackIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    if (ctrl_i.clear) begin
      state_d = PackIdle;
    end else if (ctrl_i.enable) begin
      unique case (state_q)
        PackIdle: begin
          if (ctrl_i.start) begin
            state_d = (ctrl_i.len == '0) ? PackDone : PackRun;
          end
        end
        PackRun: begin
          if (d_hs && is_last) begin
            state_d = PackDrain;
          end
        end
        PackDrain: begin
          if (q_hs) begin
            state_d = PackDone;
          end
        end
        PackDone: state_d = PackIdle;
      endcase
    end
  end

  // FSM: outputs
  always_comb begin
    d_ready = ctrl_i.enable & (state_q == PackRun) & (~out_valid_q | q_o.ready);
    flags_o      = '0;
    flags_o.busy = (state_q == PackRun) | (state_q == PackDrain);
    flags_o.done = (state_q == PackDone);
    flags_o.cnt  = PACKER_CNT_W'(cnt_q);
    flags_o.sat  = sat_q;
  end

  assign d_i.ready = d_ready;
  assign q_o.valid = out_valid_q & ctrl_i.enable;
  assign q_o.data  = out_data_q;
  assign q_o.strb  = out_strb_q;

  always_comb begin
    mode_d      = mode_q;
    sat_en_d    = sat_en_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    lane_d      = lane_q;
    pack_d      = pack_q;
    sat_d       = sat_q;
    out_data_d  = out_data_q;
    out_strb_d  = out_strb_q;
    out_valid_d = out_valid_q;
    if (ctrl_i.clear) begin
      mode_d      = PACK_32;
      sat_en_d    = 1'b0;
      len_d       = '0;
      cnt_d       = '0;
      lane_d      = '0;
      pack_d      = '0;
      sat_d       = 1'b0;
      out_data_d  = '0;
      out_strb_d  = '0;
      out_valid_d = 1'b0;
    end else if (ctrl_i.enable) begin
      if (job_start) begin
        mode_d   = ctrl_i.mode;
        sat_en_d = ctrl_i.sat_en;
        len_d    = CNT_W'(ctrl_i.len);
        cnt_d    = '0;
        lane_d   = '0;
        pack_d   = '0;
        sat_d    = 1'b0;
      end
      if (d_hs) begin
        cnt_d = cnt_q + CNT_W'(1);
        sat_d = sat_q | clip;
        if (emit) begin
          pack_d = '0;
          lane_d = '0;
        end else begin
          pack_d = merged;
          lane_d = lane_q + 2'd1;
        end
      end
      // Loading a new word wins over the handshake of the old one, so there is no bubble.
      if (emit) begin
        out_data_d  = merged;
        out_strb_d  = lane_strb(mode_q, lane_q);
        out_valid_d = 1'b1;
      end else if (q_hs) begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mode_q      <= PACK_32;
      sat_en_q    <= 1'b0;
      len_q       <= '0;
      cnt_q       <= '0;
      lane_q      <= '0;
      pack_q      <= '0;
      sat_q       <= 1'b0;
      out_data_q  <= '0;
      out_strb_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      mode_q      <= mode_d;
      sat_en_q    <= sat_en_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      lane_q      <= lane_d;
      pack_q      <= pack_d;
      sat_q       <= sat_d;
      out_data_q  <= out_data_d;
      out_strb_q  <= out_strb_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule
